// File: rtl/uart_pkg.sv
// Shared definitions for the UART boot-loader slice.
// Contents:
//   s_loader      - loader FSM state encoding
//   ACK_BYTE_DEF  - default status byte for a successful load
//   ERR_BYTE_DEF  - default status byte for a capacity error
//   UART_REG_*    - register offsets of the UART byte engine, shared with it
package uart_pkg;

    typedef enum logic [3:0] {
        IDLE,
        REQ_LEN,
        WAIT_LEN,
        CHECK,
        REQ_DATA,
        WAIT_DATA,
        WRITE,
        SEND,
        WAIT_TX
    } s_loader;

    localparam logic [7:0] ACK_BYTE_DEF = 8'hAA;
    localparam logic [7:0] ERR_BYTE_DEF = 8'hEE;

    localparam logic [3:0] UART_REG_CTRL   = 4'h0;
    localparam logic [3:0] UART_REG_STATUS = 4'h4;
    localparam logic [3:0] UART_REG_DIV    = 4'h8;
    localparam logic [3:0] UART_REG_DATA   = 4'hC;

endpackage

// File: rtl/byte_to_word_le.sv
// Little-endian byte-to-word assembler. Bytes are placed at byte lane idx
// (lane 0 = bits 7:0); idx advances per byte and wraps after lane 3, so the
// same instance serves the length header and every data word in turn.
// Ports:
//   clk, rstn  - clock, synchronous active-low reset
//   clear      - zero the index and the assembly register
//   shift      - accept byte_in into the current lane
//   byte_in    - incoming byte
//   assembled  - assembly register with byte_in already merged into lane idx
//   complete   - the byte being shifted fills lane 3 (word finished)
module byte_to_word_le (
    input  logic        clk,
    input  logic        rstn,
    input  logic        clear,
    input  logic        shift,
    input  logic [7:0]  byte_in,
    output logic [31:0] assembled,
    output logic        complete
);

    logic [1:0]  idx;
    logic [31:0] word;

    // The merged view lets the consumer capture the full word in the same
    // cycle the last byte arrives, without waiting for the register update.
    always_comb begin
        assembled = word;
        assembled[{idx, 3'b000} +: 8] = byte_in;
        complete = shift && (idx == 2'd3);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            idx  <= 2'd0;
            word <= 32'd0;
        end else if (clear) begin
            idx  <= 2'd0;
            word <= 32'd0;
        end else if (shift) begin
            idx  <= idx + 2'd1;
            word <= assembled;
        end
    end

endmodule

// File: rtl/uart_program_loader.sv
// Boot-time program loader. Pulls a little-endian 32-bit word count N and
// then N little-endian words from the UART byte engine, writes them to
// instruction memory from address 0 upward, replies with one status byte and
// pulses done. All outputs are registered.
// Ports:
//   clk, rstn                  - clock, synchronous active-low reset
//   start                      - begin a load (sampled in IDLE only)
//   busy, done, err            - status: not-idle, completion pulse, capacity error
//   u_ready                    - UART engine accepting requests
//   r_valid, rx_done, r_data   - receive-byte request / response
//   t_valid, t_data, tx_done   - transmit-byte request / acceptance
//   mem_we, mem_addr, mem_wdata - instruction memory write port
//   words_loaded               - words written in the current/last load
//
// state     | meaning
// IDLE      | waiting for start
// REQ_LEN   | waiting for u_ready to request a length byte
// WAIT_LEN  | waiting for a length byte
// CHECK     | compare N against capacity
// REQ_DATA  | waiting for u_ready to request a data byte
// WAIT_DATA | waiting for a data byte
// WRITE     | memory write strobe active, advance word count
// SEND      | waiting for u_ready to send the status byte
// WAIT_TX   | waiting for the status byte to be accepted
module uart_program_loader
    import uart_pkg::*;
#(
    parameter int         ADDR_W   = 15,
    parameter logic [7:0] ACK_BYTE = ACK_BYTE_DEF,
    parameter logic [7:0] ERR_BYTE = ERR_BYTE_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic              u_ready,
    output logic              r_valid,
    input  logic              rx_done,
    input  logic [7:0]        r_data,
    output logic              t_valid,
    output logic [7:0]        t_data,
    input  logic              tx_done,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   words_loaded
);

    // Full-width capacity so N is compared without truncation.
    localparam logic [32:0] CAPACITY = 33'd1 << ADDR_W;

    s_loader state, state_next;

    logic [31:0]       n_reg, n_next;
    logic              busy_next, done_next, err_next;
    logic              r_valid_next, t_valid_next, mem_we_next;
    logic [7:0]        t_data_next;
    logic [ADDR_W-1:0] mem_addr_next;
    logic [31:0]       mem_wdata_next;
    logic [ADDR_W:0]   words_loaded_next;

    logic              b2w_clear, b2w_shift, b2w_complete;
    logic [31:0]       b2w_word;

    byte_to_word_le u_b2w (
        .clk       (clk),
        .rstn      (rstn),
        .clear     (b2w_clear),
        .shift     (b2w_shift),
        .byte_in   (r_data),
        .assembled (b2w_word),
        .complete  (b2w_complete)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state        <= IDLE;
            n_reg        <= 32'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            r_valid      <= 1'b0;
            t_valid      <= 1'b0;
            t_data       <= 8'd0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= 32'd0;
            words_loaded <= '0;
        end else begin
            state        <= state_next;
            n_reg        <= n_next;
            busy         <= busy_next;
            done         <= done_next;
            err          <= err_next;
            r_valid      <= r_valid_next;
            t_valid      <= t_valid_next;
            t_data       <= t_data_next;
            mem_we       <= mem_we_next;
            mem_addr     <= mem_addr_next;
            mem_wdata    <= mem_wdata_next;
            words_loaded <= words_loaded_next;
        end
    end

    always_comb begin
        state_next        = state;
        n_next            = n_reg;
        done_next         = 1'b0;
        err_next          = err;
        r_valid_next      = 1'b0;
        t_valid_next      = 1'b0;
        t_data_next       = t_data;
        mem_we_next       = 1'b0;
        mem_addr_next     = mem_addr;
        mem_wdata_next    = mem_wdata;
        words_loaded_next = words_loaded;
        b2w_clear         = 1'b0;
        b2w_shift         = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    err_next          = 1'b0;
                    words_loaded_next = '0;
                    b2w_clear         = 1'b1;
                    state_next        = REQ_LEN;
                end
            end
            REQ_LEN: begin
                if (u_ready) begin
                    r_valid_next = 1'b1;
                    state_next   = WAIT_LEN;
                end
            end
            WAIT_LEN: begin
                if (rx_done) begin
                    b2w_shift = 1'b1;
                    if (b2w_complete) begin
                        n_next     = b2w_word;
                        state_next = CHECK;
                    end else begin
                        state_next = REQ_LEN;
                    end
                end
            end
            CHECK: begin
                if ({1'b0, n_reg} > CAPACITY) begin
                    err_next    = 1'b1;
                    t_data_next = ERR_BYTE;
                    state_next  = SEND;
                end else if (n_reg == 32'd0) begin
                    t_data_next = ACK_BYTE;
                    state_next  = SEND;
                end else begin
                    state_next = REQ_DATA;
                end
            end
            REQ_DATA: begin
                if (u_ready) begin
                    r_valid_next = 1'b1;
                    state_next   = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if (rx_done) begin
                    b2w_shift = 1'b1;
                    if (b2w_complete) begin
                        // Strobe registered here so mem_we is high exactly
                        // during the WRITE state.
                        mem_we_next    = 1'b1;
                        mem_addr_next  = words_loaded[ADDR_W-1:0];
                        mem_wdata_next = b2w_word;
                        state_next     = WRITE;
                    end else begin
                        state_next = REQ_DATA;
                    end
                end
            end
            WRITE: begin
                words_loaded_next = words_loaded + (ADDR_W+1)'(1);
                if ((33'(words_loaded) + 33'd1) == {1'b0, n_reg}) begin
                    t_data_next = ACK_BYTE;
                    state_next  = SEND;
                end else begin
                    state_next = REQ_DATA;
                end
            end
            SEND: begin
                if (u_ready) begin
                    t_valid_next = 1'b1;
                    state_next   = WAIT_TX;
                end
            end
            WAIT_TX: begin
                if (tx_done) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        busy_next = (state_next != IDLE);
    end

endmodule

// File: tb/tb_uart_program_loader.sv
module tb_uart_program_loader;

    localparam int         AW  = 4;
    localparam logic [7:0] ACK = 8'hAA;
    localparam logic [7:0] ERR = 8'hEE;

    logic          clk = 1'b0;
    logic          rstn;
    logic          start;
    logic          start_main = 1'b0;
    logic          start_noise = 1'b0;
    logic          busy, done, err;
    logic          u_ready;
    logic          r_valid;
    logic          rx_done;
    logic          rx_done_m, rx_done_spur = 1'b0;
    logic [7:0]    r_data;
    logic          t_valid;
    logic [7:0]    t_data;
    logic          tx_done;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [AW:0]   words_loaded;

    assign start   = start_main | start_noise;
    assign rx_done = rx_done_m | rx_done_spur;

    always #5 clk = ~clk;

    uart_program_loader #(.ADDR_W(AW)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .u_ready      (u_ready),
        .r_valid      (r_valid),
        .rx_done      (rx_done),
        .r_data       (r_data),
        .t_valid      (t_valid),
        .t_data       (t_data),
        .tx_done      (tx_done),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .words_loaded (words_loaded)
    );

    int pass_cnt = 0;
    int chk_cnt  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- UART byte engine model ----------------
    logic [7:0] stream [0:4095];
    int  wr_ptr = 0;
    int  rd_ptr = 0;
    int  rx_count = 0;
    int  unexpected = 0;
    bit  stall_mode = 1'b0;
    bit  noise_en = 1'b0;

    task automatic push_word(input logic [31:0] w);
        for (int b = 0; b < 4; b++) begin
            stream[wr_ptr] = w[8*b +: 8];
            wr_ptr++;
        end
    endtask

    initial begin
        u_ready   = 1'b1;
        rx_done_m = 1'b0;
        tx_done   = 1'b0;
        r_data    = 8'h00;
        forever begin
            @(negedge clk);
            if (r_valid) begin
                u_ready = 1'b0;
                repeat ($urandom_range(1, 4)) @(negedge clk);
                if (rd_ptr < wr_ptr) begin
                    r_data = stream[rd_ptr];
                    rd_ptr++;
                end else begin
                    r_data = 8'h00;
                    unexpected++;
                end
                rx_done_m = 1'b1;
                u_ready   = 1'b1;
                @(negedge clk);
                rx_done_m = 1'b0;
                rx_count++;
                if (stall_mode) begin
                    u_ready = 1'b0;
                    repeat (20) @(negedge clk);
                    u_ready = 1'b1;
                end
            end else if (t_valid) begin
                u_ready = 1'b0;
                repeat ($urandom_range(1, 4)) @(negedge clk);
                tx_done = 1'b1;
                u_ready = 1'b1;
                @(negedge clk);
                tx_done = 1'b0;
            end
        end
    end

    // Extra start pulses while a load is in flight (before the status byte).
    initial begin
        forever begin
            @(negedge clk);
            start_noise = noise_en && busy && !t_valid && ($urandom_range(0, 2) == 0);
        end
    end

    // ---------------- monitor ----------------
    int rcount = 0, tcount = 0, overlap = 0, ready_viol = 0, done_cnt = 0;
    logic [7:0]    last_status = 8'h00;
    logic          err_at_done = 1'b0, busy_at_done = 1'b0;
    logic [AW-1:0] wa_q [$];
    logic [31:0]   wd_q [$];
    logic          u_seen = 1'b1;

    always @(posedge clk) u_seen <= u_ready;

    always @(negedge clk) begin
        if (rstn) begin
            if (r_valid) begin
                rcount++;
                if (!u_seen) ready_viol++;
            end
            if (t_valid) begin
                tcount++;
                last_status = t_data;
                if (!u_seen) ready_viol++;
            end
            if (r_valid && t_valid) overlap++;
            if (mem_we) begin
                wa_q.push_back(mem_addr);
                wd_q.push_back(mem_wdata);
            end
            if (done) begin
                done_cnt++;
                err_at_done  = err;
                busy_at_done = busy;
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic void model_expect(input logic [31:0] n, output bit e,
                                         output logic [7:0] s, output int w);
        longint unsigned cap = longint'(1) << AW;
        if (longint'(n) > cap) begin
            e = 1'b1; s = ERR; w = 0;
        end else begin
            e = 1'b0; s = ACK; w = int'(n);
        end
    endfunction

    task automatic run_load(input string tag, input logic [31:0] n, input bit stall,
                            input bit noise, input bit exp_err, input logic [7:0] exp_status,
                            input int exp_writes, input bit fixed);
        logic [31:0] words [16];
        int r0, t0, d0, w0, u0, ov0, rv0, cyc, got_w;
        for (int i = 0; i < 16; i++) words[i] = $urandom();
        if (fixed) begin
            words[0] = 32'h1234_5678;
            words[1] = 32'hDEAD_BEEF;
        end
        stall_mode = stall;
        push_word(n);
        for (int i = 0; i < exp_writes; i++) push_word(words[i]);
        r0 = rcount; t0 = tcount; d0 = done_cnt; w0 = wa_q.size();
        u0 = unexpected; ov0 = overlap; rv0 = ready_viol;
        if (noise) begin
            @(negedge clk) rx_done_spur = 1'b1;
            @(negedge clk) rx_done_spur = 1'b0;
        end
        @(negedge clk) start_main = 1'b1;
        @(negedge clk) start_main = 1'b0;
        noise_en = noise;
        cyc = 0;
        while (done_cnt == d0 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        noise_en = 1'b0;
        check({tag, " done_seen"}, 64'(done_cnt != d0), 64'd1);
        repeat (3) @(negedge clk);
        check({tag, " done_pulses"}, 64'(done_cnt - d0), 64'd1);
        check({tag, " err"}, 64'(err_at_done), 64'(exp_err));
        check({tag, " busy_at_done"}, 64'(busy_at_done), 64'd0);
        check({tag, " status_count"}, 64'(tcount - t0), 64'd1);
        check({tag, " status_byte"}, 64'(last_status), 64'(exp_status));
        check({tag, " byte_requests"}, 64'(rcount - r0), 64'(4 + 4 * exp_writes));
        check({tag, " unexpected_req"}, 64'(unexpected - u0), 64'd0);
        check({tag, " overlap"}, 64'(overlap - ov0), 64'd0);
        check({tag, " ready_violations"}, 64'(ready_viol - rv0), 64'd0);
        check({tag, " words_loaded"}, 64'(words_loaded), 64'(exp_writes));
        got_w = wa_q.size() - w0;
        check({tag, " write_count"}, 64'(got_w), 64'(exp_writes));
        for (int i = 0; i < exp_writes && i < got_w; i++) begin
            check({tag, " write_addr"}, 64'(wa_q[w0 + i]), 64'(i));
            check({tag, " write_data"}, 64'(wd_q[w0 + i]), 64'(words[i]));
        end
    endtask

    function automatic logic [63:0] out_vec();
        return 64'({busy, done, err, r_valid, t_valid, t_data, mem_we,
                    mem_addr, mem_wdata, words_loaded});
    endfunction

    typedef struct {
        logic [31:0] n;
        bit          stall;
        bit          noise;
        bit          exp_err;
        logic [7:0]  exp_status;
        int          exp_writes;
    } vec_t;

    vec_t vecs [8];

    initial begin
        bit          e;
        logic [7:0]  s;
        int          w;
        logic [31:0] n;
        bit          st;
        int          cyc, rx0, t0, r0, d0, w0;

        vecs[0] = '{32'd2,         1'b0, 1'b0, 1'b0, ACK, 2};
        vecs[1] = '{32'd0,         1'b0, 1'b0, 1'b0, ACK, 0};
        vecs[2] = '{32'd17,        1'b0, 1'b0, 1'b1, ERR, 0};
        vecs[3] = '{32'd16,        1'b0, 1'b0, 1'b0, ACK, 16};
        vecs[4] = '{32'd3,         1'b1, 1'b0, 1'b0, ACK, 3};
        vecs[5] = '{32'd4,         1'b0, 1'b1, 1'b0, ACK, 4};
        vecs[6] = '{32'h0001_0003, 1'b0, 1'b0, 1'b1, ERR, 0};
        vecs[7] = '{32'd1,         1'b0, 1'b0, 1'b0, ACK, 1};

        rstn = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", out_vec(), 64'd0);
        rstn = 1'b1;
        @(negedge clk);
        check("idle_after_reset", out_vec(), 64'd0);

        for (int i = 0; i < 8; i++) begin
            run_load($sformatf("vec%0d", i), vecs[i].n, vecs[i].stall, vecs[i].noise,
                     vecs[i].exp_err, vecs[i].exp_status, vecs[i].exp_writes, i == 0);
        end

        for (int i = 0; i < 6; i++) begin
            n  = 32'($urandom_range(0, 20));
            st = ($urandom_range(0, 3) == 0);
            model_expect(n, e, s, w);
            run_load($sformatf("rand%0d", i), n, st, 1'b0, e, s, w, 1'b0);
        end

        // Reset after the length header plus five data bytes.
        stall_mode = 1'b1;
        push_word(32'd3);
        push_word(32'hCAFE_F00D);
        stream[wr_ptr] = 8'h11;
        wr_ptr++;
        rx0 = rx_count; w0 = wa_q.size();
        @(negedge clk) start_main = 1'b1;
        @(negedge clk) start_main = 1'b0;
        cyc = 0;
        while ((rx_count - rx0) < 9 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        check("rst_test reached_9_bytes", 64'((rx_count - rx0) >= 9), 64'd1);
        check("rst_test first_write_kept", 64'(wa_q.size() - w0), 64'd1);
        rstn = 1'b0;
        @(negedge clk);
        check("rst_test outputs_zero", out_vec(), 64'd0);
        rstn = 1'b1;
        t0 = tcount; r0 = rcount; d0 = done_cnt;
        repeat (30) @(negedge clk);
        check("rst_test no_status", 64'(tcount - t0), 64'd0);
        check("rst_test no_requests", 64'(rcount - r0), 64'd0);
        check("rst_test no_done", 64'(done_cnt - d0), 64'd0);
        check("rst_test busy", 64'(busy), 64'd0);
        stall_mode = 1'b0;
        run_load("after_reset", 32'd2, 1'b0, 1'b0, 1'b0, ACK, 2, 1'b1);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/uart_program_loader.md
Name: uart_program_loader

Overview:
- Boot-time loader directly upstream of the UART byte engine; drives that engine's byte request/response interface (r_valid/rx_done/r_data, t_valid/tx_done/t_data, u_ready).
- Receives a little-endian 32-bit word count N, then N little-endian 32-bit words, and writes each word to instruction memory.
- Replies with one status byte, then pulses done so the core can leave reset/boot mode.

Parameters:
ADDR_W, 15, instruction memory word-address width; capacity = 2^ADDR_W words
ACK_BYTE, 8'hAA, status byte sent after a successful load
ERR_BYTE, 8'hEE, status byte sent when N exceeds capacity

Ports:
clk  in  1  clock
rstn  in  1  reset; synchronous, active-low
start  in  1  begin a load; sampled only in IDLE
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when the load completes (success or error)
err  out  1  level, set with done on capacity error; cleared on next start or reset
u_ready  in  1  UART engine idle and accepting requests
r_valid  out  1  receive-byte request to UART, one-cycle pulse
rx_done  in  1  one-cycle pulse; r_data valid in the same cycle
r_data  in  8  received byte
t_valid  out  1  transmit-byte request to UART, one-cycle pulse
t_data  out  8  byte to transmit; held stable from t_valid until tx_done
tx_done  in  1  one-cycle pulse, transmit accepted
mem_we  out  1  one-cycle word write strobe
mem_addr  out  ADDR_W  word address, valid with mem_we
mem_wdata  out  32  word data, valid with mem_we
words_loaded  out  ADDR_W+1  words written so far in current/last load

Behaviour:
- All outputs are registered.
- Reset values: busy=0, done=0, err=0, r_valid=0, t_valid=0, t_data=0, mem_we=0, mem_addr=0, mem_wdata=0, words_loaded=0. State returns to IDLE.
- Reset mid-load aborts immediately. No status byte is sent and partial memory contents are left as they are.
- States and transitions:
  - IDLE: on start, clear err, clear words_loaded, clear byte index -> REQ_LEN.
  - REQ_LEN / REQ_DATA: wait for u_ready=1, then r_valid<=1 for exactly one cycle -> WAIT_LEN / WAIT_DATA.
  - WAIT_LEN / WAIT_DATA: on rx_done, shift r_data into the assembly register at byte position idx (byte0 = bits 7:0), idx++.
    - idx<3: back to the matching REQ state.
    - idx==3 in WAIT_LEN: latch N -> CHECK.
    - idx==3 in WAIT_DATA -> WRITE.
  - CHECK:
    - N > 2^ADDR_W: err<=1, t_data<=ERR_BYTE -> SEND.
    - N==0: t_data<=ACK_BYTE -> SEND.
    - Otherwise -> REQ_DATA.
  - WRITE (one cycle): mem_we=1, mem_addr=words_loaded[ADDR_W-1:0], mem_wdata=assembled word; words_loaded++. Next state is SEND (t_data<=ACK_BYTE) if words_loaded+1==N, else REQ_DATA.
  - SEND: wait for u_ready=1, then t_valid<=1 for one cycle -> WAIT_TX.
  - WAIT_TX: on tx_done, done<=1 for one cycle -> IDLE.
- Handshake rules:
  - r_valid and t_valid are never high in the same cycle.
  - A new request is never issued in the same cycle as rx_done/tx_done. The UART's u_ready is high in that cycle, so the REQ state is entered one cycle later and re-checks u_ready.
  - rx_done or tx_done arriving in any state other than its WAIT state is ignored.
- start while busy is ignored. start in the same cycle as done's IDLE return is sampled the cycle after (IDLE only).
- Latency per byte = 2 cycles + UART latency. Per word = 4 bytes + 1 WRITE cycle.
- Address boundary: N == 2^ADDR_W is legal. The last write goes to mem_addr all-ones; words_loaded ends at 2^ADDR_W (hence ADDR_W+1 bits). No wrap ever occurs.
- The length comparison uses full 32-bit N against 33-bit 2^ADDR_W. No truncation.

Decomposition:
- Shared package uart_pkg:
  - typedef enum s_loader {IDLE, REQ_LEN, WAIT_LEN, CHECK, REQ_DATA, WAIT_DATA, WRITE, SEND, WAIT_TX}
  - ACK_BYTE/ERR_BYTE defaults
  - UART register-offset constants shared with the UART engine
- One natural sub-module: byte_to_word_le (2-bit index plus 32-bit shift/assemble register with clear and word-complete flag). It is reused for the length header and for data words.

Test Plan:
- N=2, bytes 02 00 00 00 | 78 56 34 12 | EF BE AD DE -> mem_we at addr 0 data 0x12345678, at addr 1 data 0xDEADBEEF; t_data=0xAA with one t_valid; done pulse; err=0; words_loaded=2.
- N=0 (00 00 00 00) -> no mem_we; ACK 0xAA sent; done=1 err=0.
- ADDR_W=4, N=17 (11 00 00 00) -> no mem_we; t_data=0xEE; done with err=1. Then N=16 -> 16 writes, last at addr 0xF, words_loaded=16, err cleared.
- u_ready held low 20 cycles after each rx_done -> r_valid asserted only once u_ready=1; exactly one request per byte, never overlapping t_valid.
- rstn low for 1 cycle after 5 data bytes received -> all outputs at reset values next cycle, busy=0, no t_valid. A new start then loads correctly from addr 0.
- start pulsed repeatedly during a load, plus spurious rx_done in IDLE -> ignored; sequence and write count unchanged.
